// File: rtl/keyvalue_pkg.sv
// -----------------------------------------------------------------------------
// keyvalue_pkg
// Shared definitions for the key/value store: Wishbone register addresses,
// command opcodes, the controller state encoding and small helper functions.
// -----------------------------------------------------------------------------
package keyvalue_pkg;

    // Register map (ADR_i)
    localparam logic [1:0] ADR_KEY    = 2'd0;
    localparam logic [1:0] ADR_VALUE  = 2'd1;
    localparam logic [1:0] ADR_CMD    = 2'd2;
    localparam logic [1:0] ADR_STATUS = 2'd3;

    // Command opcodes (DAT_i[2:0] on a CMD write)
    localparam logic [2:0] OP_PUT   = 3'd1;
    localparam logic [2:0] OP_GET   = 3'd2;
    localparam logic [2:0] OP_DEL   = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    // Count is 9 bits so that DEPTH=256 is representable.
    localparam int CNT_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Replace the bytes of old_w selected by sel with the matching bytes of new_w.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[b*8 +: 8] = new_w[b*8 +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_PUT) || (op == OP_GET) || (op == OP_DEL) || (op == OP_CLEAR);
    endfunction

endpackage

// File: rtl/keyvalue_array.sv
// -----------------------------------------------------------------------------
// keyvalue_array
// DEPTH entries of {key, value} storage with a per-entry valid bit.
// One combinational read port (driven by the scan index) and one write port.
// A write with i_wr_valid=1 stores key/value and marks the entry valid; a
// write with i_wr_valid=0 only invalidates the entry. i_clr_all invalidates
// every entry in one cycle.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset (valid bits only)
//   i_rd_idx            read index
//   o_rd_valid/key/val  entry at i_rd_idx
//   i_wr_en, i_wr_idx   write strobe and index
//   i_wr_valid          new valid bit for the written entry
//   i_wr_key, i_wr_val  data stored when i_wr_valid=1
//   i_clr_all           invalidate all entries
// -----------------------------------------------------------------------------
module keyvalue_array #(
    parameter int KEY_W = 8,
    parameter int VAL_W = 8,
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_valid,
    output logic [KEY_W-1:0] o_rd_key,
    output logic [VAL_W-1:0] o_rd_val,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_valid,
    input  logic [KEY_W-1:0] i_wr_key,
    input  logic [VAL_W-1:0] i_wr_val,
    input  logic             i_clr_all
);

    logic [DEPTH-1:0] r_valid;
    logic [KEY_W-1:0] r_key_mem [DEPTH];
    logic [VAL_W-1:0] r_val_mem [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
        end else if (i_clr_all) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= i_wr_valid;
        end
    end

    // NOTE: the data arrays are deliberately left out of reset; an entry is
    // only ever observed through its valid bit, so resetting the payload would
    // just add reset fan-out for no functional gain.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && i_wr_valid) begin
            r_key_mem[i_wr_idx] <= i_wr_key;
            r_val_mem[i_wr_idx] <= i_wr_val;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_key   = r_key_mem[i_rd_idx];
    assign o_rd_val   = r_val_mem[i_rd_idx];

endmodule

// File: rtl/keyvalue_store.sv
// -----------------------------------------------------------------------------
// keyvalue_store
// Small associative key/value store behind a Wishbone-style slave port.
// Software loads KEY/VALUE, then writes CMD (PUT/GET/DEL/CLEAR). PUT/GET/DEL
// scan the array one entry per cycle; CLEAR completes immediately.
//
// Ports:
//   sys_clk, sys_rst   clock, asynchronous active-high reset
//   STB_i, CYC_i       request valid when both high
//   WE_i, SEL_i        write enable, byte selects
//   ADR_i              0 KEY, 1 VALUE, 2 CMD, 3 STATUS
//   DAT_i / DAT_o      write data / read data (0 when ACK_o is low)
//   ACK_o              one-cycle acknowledge
//   LA_o               debug: [7:0] state, [15:8] scan index, [24:16] count,
//                      [25] hit, [26] full, [27] err
// -----------------------------------------------------------------------------
module keyvalue_store
    import keyvalue_pkg::*;
#(
    parameter int KEY_W = 8,
    parameter int VAL_W = 8,
    parameter int DEPTH = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        STB_i,
    input  logic        CYC_i,
    input  logic        WE_i,
    input  logic [3:0]  SEL_i,
    input  logic [1:0]  ADR_i,
    input  logic [31:0] DAT_i,
    output logic [31:0] DAT_o,
    output logic        ACK_o,
    output logic [31:0] LA_o
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_free_idx;
    logic             r_free_found;
    logic [2:0]       r_op;
    logic [KEY_W-1:0] r_key;
    logic [VAL_W-1:0] r_val;
    logic [CNT_W-1:0] r_count;
    logic             r_hit;
    logic             r_err;
    logic             r_ack;
    logic [31:0]      r_dat;

    logic             w_rd_valid;
    logic [KEY_W-1:0] w_rd_key;
    logic [VAL_W-1:0] w_rd_val;

    logic             w_req;
    logic             w_cmd_ok;
    logic             w_scan_start;
    logic             w_clear;
    logic             w_match;
    logic             w_last;
    logic             w_free_found;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_full;
    logic             w_busy;
    logic [31:0]      w_key_merged;
    logic [31:0]      w_val_merged;
    logic [31:0]      w_status;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_wr_valid;

    // Requests are only taken in IDLE and not in the cycle a register ACK is
    // already showing, so a master that holds STB until it sees ACK is not
    // serviced twice.
    assign w_req        = STB_i && CYC_i && (r_state == ST_IDLE) && !r_ack;
    assign w_cmd_ok     = w_req && WE_i && (ADR_i == ADR_CMD) && SEL_i[0]
                          && is_legal_op(DAT_i[2:0]);
    assign w_clear      = w_cmd_ok && (DAT_i[2:0] == OP_CLEAR);
    assign w_scan_start = w_cmd_ok && (DAT_i[2:0] != OP_CLEAR);

    assign w_match = w_rd_valid && (w_rd_key == r_key);
    assign w_last  = (r_idx == IDX_W'(DEPTH - 1));

    // The entry under examination this cycle may itself be the first free one.
    assign w_free_found = r_free_found || !w_rd_valid;
    assign w_free_idx   = r_free_found ? r_free_idx : r_idx;

    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_busy = (r_state != ST_IDLE);

    assign w_key_merged = byte_merge(32'(r_key), DAT_i, SEL_i);
    assign w_val_merged = byte_merge(32'(r_val), DAT_i, SEL_i);
    // Upper merged bits beyond KEY_W/VAL_W are intentionally discarded.
    assign w_unused     = ^{w_key_merged, w_val_merged};

    always_comb begin
        w_status        = '0;
        w_status[0]     = w_busy;
        w_status[1]     = r_hit;
        w_status[2]     = w_full;
        w_status[3]     = r_err;
        w_status[16:8]  = r_count;
    end

    always_comb begin
        w_rd_mux = '0;
        case (ADR_i)
            ADR_KEY:    w_rd_mux = 32'(r_key);
            ADR_VALUE:  w_rd_mux = 32'(r_val);
            ADR_CMD:    w_rd_mux = '0;
            ADR_STATUS: w_rd_mux = w_status;
            default:    w_rd_mux = '0;
        endcase
    end

    keyvalue_array #(
        .KEY_W (KEY_W),
        .VAL_W (VAL_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .i_clk      (sys_clk),
        .i_rst      (sys_rst),
        .i_rd_idx   (r_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_key   (w_rd_key),
        .o_rd_val   (w_rd_val),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (w_wr_idx),
        .i_wr_valid (w_wr_valid),
        .i_wr_key   (r_key),
        .i_wr_val   (r_val),
        .i_clr_all  (w_clear)
    );

    // FSM state register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_wr_idx     = r_idx;
        w_wr_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_clear) begin
                    w_next_state = ST_DONE;
                end else if (w_scan_start) begin
                    w_next_state = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_match || w_last) begin
                    w_next_state = ST_DONE;
                    if (r_op == OP_PUT) begin
                        if (w_match) begin
                            w_wr_en    = 1'b1;
                            w_wr_valid = 1'b1;
                        end else if (w_free_found) begin
                            w_wr_en    = 1'b1;
                            w_wr_idx   = w_free_idx;
                            w_wr_valid = 1'b1;
                        end
                    end else if (r_op == OP_DEL && w_match) begin
                        w_wr_en = 1'b1;
                    end
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: register file, scan bookkeeping, count, flags and bus response.
    // NOTE: all state here uses non-blocking assignment so the per-cycle
    // defaults for r_ack/r_dat and the later overrides resolve in order without
    // creating read-after-write races between registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_idx        <= '0;
            r_free_idx   <= '0;
            r_free_found <= 1'b0;
            r_op         <= '0;
            r_key        <= '0;
            r_val        <= '0;
            r_count      <= '0;
            r_hit        <= 1'b0;
            r_err        <= 1'b0;
            r_ack        <= 1'b0;
            r_dat        <= '0;
        end else begin
            r_ack <= 1'b0;
            r_dat <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        // Everything but a scanning command is answered next cycle.
                        r_ack <= !w_scan_start;
                        if (!WE_i) begin
                            r_dat <= w_rd_mux;
                        end else begin
                            case (ADR_i)
                                ADR_KEY:   r_key <= w_key_merged[KEY_W-1:0];
                                ADR_VALUE: r_val <= w_val_merged[VAL_W-1:0];
                                ADR_CMD: begin
                                    if (w_cmd_ok) begin
                                        r_op         <= DAT_i[2:0];
                                        r_idx        <= '0;
                                        r_free_idx   <= '0;
                                        r_free_found <= 1'b0;
                                        if (w_clear) begin
                                            r_count <= '0;
                                            r_hit   <= 1'b0;
                                            r_err   <= 1'b0;
                                        end
                                    end else begin
                                        r_err <= 1'b1;
                                    end
                                end
                                default: ; // STATUS is read-only
                            endcase
                        end
                    end
                end
                ST_SCAN: begin
                    if (w_match || w_last) begin
                        r_ack <= 1'b1;
                        r_hit <= w_match;
                        case (r_op)
                            OP_PUT: begin
                                if (w_match) begin
                                    r_err <= 1'b0;
                                end else if (w_free_found) begin
                                    r_count <= r_count + CNT_W'(1);
                                    r_err   <= 1'b0;
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end
                            OP_GET: begin
                                r_val <= w_match ? w_rd_val : '0;
                                r_err <= 1'b0;
                            end
                            OP_DEL: begin
                                if (w_match) begin
                                    r_count <= r_count - CNT_W'(1);
                                    r_err   <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                        if (!r_free_found && !w_rd_valid) begin
                            r_free_found <= 1'b1;
                            r_free_idx   <= r_idx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ACK_o = r_ack;
    assign DAT_o = r_ack ? r_dat : '0;
    assign LA_o  = {4'b0, r_err, w_full, r_hit, r_count, 8'(r_idx), 8'(r_state)};

endmodule

// File: tb/tb_keyvalue_store.sv
// -----------------------------------------------------------------------------
// tb_keyvalue_store
// Directed bench for keyvalue_store with DEPTH=4, KEY_W=VAL_W=8. A table of
// bus transactions with expected ACK latency and read data is replayed first,
// followed by hand-written sequences for bus drop during SCAN, requests while
// busy and reset during SCAN.
// -----------------------------------------------------------------------------
module tb_keyvalue_store;

    localparam int KEY_W  = 8;
    localparam int VAL_W  = 8;
    localparam int DEPTH  = 4;
    localparam int BUDGET = 40;

    localparam logic [1:0] A_KEY  = 2'd0;
    localparam logic [1:0] A_VAL  = 2'd1;
    localparam logic [1:0] A_CMD  = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        STB_i, CYC_i, WE_i;
    logic [3:0]  SEL_i;
    logic [1:0]  ADR_i;
    logic [31:0] DAT_i;
    logic [31:0] DAT_o;
    logic        ACK_o;
    logic [31:0] LA_o;

    int n_checks = 0;
    int n_errors = 0;

    keyvalue_store #(
        .KEY_W (KEY_W),
        .VAL_W (VAL_W),
        .DEPTH (DEPTH)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .STB_i   (STB_i),
        .CYC_i   (CYC_i),
        .WE_i    (WE_i),
        .SEL_i   (SEL_i),
        .ADR_i   (ADR_i),
        .DAT_i   (DAT_i),
        .DAT_o   (DAT_o),
        .ACK_o   (ACK_o),
        .LA_o    (LA_o)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [1:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input int lat, input logic [31:0] exp);
        vec_t v;
        v.we = we; v.adr = adr; v.sel = sel; v.dat = dat; v.lat = lat; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic wkey(input logic [31:0] k);           add(1'b1, A_KEY, 4'hF, k, 1, 32'h0); endtask
    task automatic wval(input logic [31:0] v);           add(1'b1, A_VAL, 4'hF, v, 1, 32'h0); endtask
    task automatic cmd(input logic [31:0] op, input int lat); add(1'b1, A_CMD, 4'hF, op, lat, 32'h0); endtask
    task automatic rd(input logic [1:0] a, input logic [31:0] e); add(1'b0, a, 4'hF, 32'h0, 1, e); endtask

    // One bus transaction: latency counts cycles after the sampling edge until
    // ACK is seen (1 = next cycle); -1 if the budget expires. One idle cycle
    // follows so the next request starts cleanly.
    task automatic do_req(input logic we, input logic [1:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, output logic [31:0] rdata, output int lat);
        WE_i = we; ADR_i = adr; SEL_i = sel; DAT_i = dat;
        STB_i = 1'b1; CYC_i = 1'b1;
        @(posedge sys_clk); #1;
        lat = 1;
        while (!ACK_o && lat < BUDGET) begin
            @(posedge sys_clk); #1;
            lat++;
        end
        if (!ACK_o) lat = -1;
        rdata = DAT_o;
        STB_i = 1'b0; CYC_i = 1'b0; WE_i = 1'b0;
        @(posedge sys_clk); #1;
    endtask

    task automatic req_chk(input string name, input logic we, input logic [1:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat,
                           input int exp_lat, input logic [31:0] exp_dat);
        logic [31:0] r;
        int          l;
        do_req(we, adr, sel, dat, r, l);
        check({name, "_lat"}, 32'(l), 32'(exp_lat));
        check({name, "_dat"}, r, exp_dat);
    endtask

    initial begin
        logic [31:0] r;
        int          l;
        int          acks;

        sys_rst = 1'b1;
        STB_i = 1'b0; CYC_i = 1'b0; WE_i = 1'b0;
        SEL_i = 4'h0; ADR_i = 2'd0; DAT_i = 32'h0;
        #1;
        check("rst_ack", 32'(ACK_o), 32'h0);
        check("rst_dat", DAT_o, 32'h0);
        check("rst_la",  LA_o, 32'h0);
        @(posedge sys_clk); @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;

        // ---------------- stimulus table ----------------
        rd(A_STAT, 32'h0); rd(A_KEY, 32'h0); rd(A_VAL, 32'h0);
        // PUT 0x11/0xAA into empty store (miss, m=3), then GET it back (m=0)
        wkey(32'h11); wval(32'hAA); cmd(1, 5);
        rd(A_STAT, 32'h100);
        wval(32'h00); cmd(2, 2);
        rd(A_VAL, 32'hAA); rd(A_STAT, 32'h102);
        // Fill the store, overflow it, look up missing and present keys
        cmd(4, 1); rd(A_STAT, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            wkey(32'(k)); cmd(1, 5);
        end
        rd(A_STAT, 32'h404);
        wkey(32'h5); cmd(1, 5);
        rd(A_STAT, 32'h40C);
        cmd(2, 5); rd(A_VAL, 32'h0); rd(A_STAT, 32'h404);
        wkey(32'h4); cmd(2, 5); rd(A_VAL, 32'hAA); rd(A_STAT, 32'h406);
        // Delete creates a hole that the next PUT reuses (index 1)
        cmd(4, 1);
        for (int k = 1; k <= 3; k++) begin
            wkey(32'(k)); cmd(1, 5);
        end
        wkey(32'h2); cmd(3, 3); rd(A_STAT, 32'h202);
        wkey(32'h9); wval(32'h99); cmd(1, 5); rd(A_STAT, 32'h300);
        wval(32'h00); cmd(2, 3); rd(A_VAL, 32'h99);
        // PUT on existing key overwrites, count unchanged
        cmd(4, 1);
        wkey(32'h7); wval(32'h01); cmd(1, 5);
        wval(32'h02); cmd(1, 2); rd(A_STAT, 32'h102);
        wval(32'h00); cmd(2, 2); rd(A_VAL, 32'h02);
        // Illegal opcode, byte-select masking, CLEAR
        cmd(6, 1); rd(A_STAT, 32'h10A);
        add(1'b1, A_KEY, 4'b0001, 32'hFFFF_FF33, 1, 32'h0); rd(A_KEY, 32'h33);
        cmd(4, 1); rd(A_STAT, 32'h0);
        add(1'b1, A_CMD, 4'b0010, 32'h1, 1, 32'h0); rd(A_STAT, 32'h8);
        wval(32'h1234_5677); rd(A_VAL, 32'h77);
        add(1'b1, A_VAL, 4'b0010, 32'h0000_FF00, 1, 32'h0); rd(A_VAL, 32'h77);

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, r, l);
            check($sformatf("v%0d_lat", i), 32'(l), 32'(vecs[i].lat));
            check($sformatf("v%0d_dat", i), r, vecs[i].exp);
        end

        // ---------------- bus dropped during SCAN, request while busy ----------------
        req_chk("a_clear", 1'b1, A_CMD, 4'hF, 32'h4, 1, 32'h0);
        req_chk("a_key", 1'b1, A_KEY, 4'hF, 32'h42, 1, 32'h0);
        WE_i = 1'b1; ADR_i = A_CMD; SEL_i = 4'hF; DAT_i = 32'h1;
        STB_i = 1'b1; CYC_i = 1'b1;
        @(posedge sys_clk); #1;
        check("a_ack_c1", 32'(ACK_o), 32'h0);
        check("a_la_c1", LA_o & 32'hFFFF, 32'h0001);
        STB_i = 1'b0; CYC_i = 1'b0; WE_i = 1'b0;
        @(posedge sys_clk); #1;
        check("a_la_c2", LA_o & 32'hFFFF, 32'h0101);
        ADR_i = A_STAT; STB_i = 1'b1; CYC_i = 1'b1;
        @(posedge sys_clk); #1;
        STB_i = 1'b0; CYC_i = 1'b0;
        check("a_la_c3", LA_o & 32'hFFFF, 32'h0201);
        l = 3;
        while (!ACK_o && l < BUDGET) begin
            @(posedge sys_clk); #1;
            l++;
        end
        check("a_put_lat", 32'(l), 32'd5);
        @(posedge sys_clk); #1;
        check("a_ack_pulse", 32'(ACK_o), 32'h0);
        @(posedge sys_clk); #1;
        check("a_busy_ignored", 32'(ACK_o), 32'h0);
        req_chk("a_stat", 1'b0, A_STAT, 4'hF, 32'h0, 1, 32'h100);

        // ---------------- reset during SCAN ----------------
        req_chk("b_key", 1'b1, A_KEY, 4'hF, 32'h55, 1, 32'h0);
        WE_i = 1'b1; ADR_i = A_CMD; SEL_i = 4'hF; DAT_i = 32'h1;
        STB_i = 1'b1; CYC_i = 1'b1;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        STB_i = 1'b0; CYC_i = 1'b0; WE_i = 1'b0;
        #1;
        check("b_rst_ack", 32'(ACK_o), 32'h0);
        check("b_rst_la", LA_o, 32'h0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge sys_clk); #1;
            if (ACK_o) acks++;
        end
        check("b_no_ack", 32'(acks), 32'h0);
        req_chk("b_stat", 1'b0, A_STAT, 4'hF, 32'h0, 1, 32'h0);
        req_chk("b_keyrd", 1'b0, A_KEY, 4'hF, 32'h0, 1, 32'h0);
        req_chk("b_key2", 1'b1, A_KEY, 4'hF, 32'h55, 1, 32'h0);
        req_chk("b_get", 1'b1, A_CMD, 4'hF, 32'h2, 5, 32'h0);
        req_chk("b_stat2", 1'b0, A_STAT, 4'hF, 32'h0, 1, 32'h0);
        req_chk("b_get42", 1'b1, A_KEY, 4'hF, 32'h42, 1, 32'h0);
        req_chk("b_get42c", 1'b1, A_CMD, 4'hF, 32'h2, 5, 32'h0);
        req_chk("b_val", 1'b0, A_VAL, 4'hF, 32'h0, 1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
